// File: rtl/icache_pkg.sv
// icache_pkg: shared types and sizing for the direct-mapped instruction cache.
package icache_pkg;

  // Number of one-word frames; must stay a power of two.
  localparam int SETS  = 16;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 2 - IDX_W;

  // Fetch address as seen by the cache: tag | frame index | byte offset.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  // One cache frame: valid bit, stored tag, one instruction word.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Rebuild the word-aligned memory address of a frame from its tag and index.
  function automatic logic [31:0] frame_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
    return {tag, idx, 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch port (datapath side) and word-read port (memory side)
// of the instruction cache, bundled into one interface.
interface icache_if;

  // datapath <-> cache
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  // cache <-> memory controller
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // The cache itself: serves fetches, issues memory reads.
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // The environment around the cache: datapath plus memory controller.
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache.sv
// icache: direct-mapped, one-word-block, read-only instruction cache.
// Hits answer in the same cycle; a miss stalls the fetch (ihit=0) while a
// single word is read from memory, then the word is served from the array
// in the following IDLE cycle.
module icache
  import icache_pkg::*;
(
  input logic    CLK,
  input logic    nRST,
  icache_if.slave cif
);

  icache_state_t    state_reg, state_next;
  icachef_t         req;
  icache_frame_t    lookup_frame;

  logic [TAG_W-1:0] miss_tag_reg;
  logic [IDX_W-1:0] miss_idx_reg;
  logic [SETS-1:0]  valid_reg;
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [31:0]      data_arr [SETS];

  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;

  logic             hit;
  logic             miss_start;
  logic             fill;
  logic             ihit_next;
  logic [31:0]      imemload_next;
  logic             iren_next;
  logic [31:0]      iaddr_next;

  // The byte offset and the statistics counters feed no logic.
  logic             unused_sink;
  assign unused_sink = ^{req.bytoff, hit_cnt, miss_cnt};

  assign req = icachef_t'(cif.imemaddr);

  // Frame addressed by the live fetch; the tag check needs it in the same
  // cycle, so the arrays are read asynchronously.
  always_comb begin
    lookup_frame       = '0;
    lookup_frame.valid = valid_reg[req.idx];
    lookup_frame.tag   = tag_arr[req.idx];
    lookup_frame.data  = data_arr[req.idx];
  end

  // Next-state and output decode; lookups happen only in IDLE, so a fill
  // and a lookup can never coincide.
  always_comb begin
    state_next    = state_reg;
    hit           = 1'b0;
    miss_start    = 1'b0;
    fill          = 1'b0;
    ihit_next     = 1'b0;
    imemload_next = '0;
    iren_next     = 1'b0;
    iaddr_next    = '0;
    case (state_reg)
      IDLE: begin
        if (cif.imemREN) begin
          if (lookup_frame.valid && (lookup_frame.tag == req.tag)) begin
            hit           = 1'b1;
            ihit_next     = 1'b1;
            imemload_next = lookup_frame.data;
          end else begin
            miss_start = 1'b1;
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        // Address comes from the miss latch so a redirect cannot corrupt
        // the outstanding read.
        iren_next  = 1'b1;
        iaddr_next = frame_addr(miss_tag_reg, miss_idx_reg);
        if (!cif.iwait) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cif.ihit     = ihit_next;
  assign cif.imemload = imemload_next;
  assign cif.iREN     = iren_next;
  assign cif.iaddr    = iaddr_next;

  // State register; reset drops iREN at once because iREN decodes FETCH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Capture the missing tag/index when leaving IDLE for FETCH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_tag_reg <= '0;
      miss_idx_reg <= '0;
    end else if (miss_start) begin
      miss_tag_reg <= req.tag;
      miss_idx_reg <= req.idx;
    end
  end

  // Per-frame valid bits: cleared by reset, set when their frame is filled.
  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
      // Valid flag of frame gi.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                                    valid_reg[gi] <= 1'b0;
        else if (fill && (miss_idx_reg == IDX_W'(gi))) valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  // Tag and data storage: written on the fill edge, overwriting whatever the
  // frame held (read-only cache, nothing to write back). No reset needed.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_arr[miss_idx_reg]  <= miss_tag_reg;
      data_arr[miss_idx_reg] <= cif.iload;
    end
  end

  // Hit/miss statistics for simulation visibility; wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)        hit_cnt  <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for the instruction cache. Inputs change 1 ns
// after each rising edge, outputs are compared 1 ns later.
module tb_icache;

  logic CLK;
  logic nRST;
  int   n_vec;
  int   n_err;

  icache_if cif ();

  icache dut (
    .CLK  (CLK),
    .nRST (nRST),
    .cif  (cif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Apply one cycle's inputs and let the combinational outputs settle.
  task automatic drive(input logic ren, input logic [31:0] addr,
                       input logic wt, input logic [31:0] load);
    cif.imemREN  = ren;
    cif.imemaddr = addr;
    cif.iwait    = wt;
    cif.iload    = load;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full miss on addr: one IDLE miss cycle, `waits` busy cycles, one data cycle.
  task automatic do_miss(input string tag, input logic [31:0] addr,
                         input int waits, input logic [31:0] data);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    drive(1'b1, addr, 1'b1, 32'h0);
    chk({tag, " miss ihit"}, 32'(cif.ihit), 32'h0);
    chk({tag, " miss iREN"}, 32'(cif.iREN), 32'h0);
    cyc();
    for (int i = 0; i < waits; i++) begin
      drive(1'b1, addr, 1'b1, 32'h0);
      chk({tag, " wait iREN"},  32'(cif.iREN), 32'h1);
      chk({tag, " wait iaddr"}, cif.iaddr, word_addr);
      chk({tag, " wait ihit"},  32'(cif.ihit), 32'h0);
      cyc();
    end
    drive(1'b1, addr, 1'b0, data);
    chk({tag, " load iREN"},  32'(cif.iREN), 32'h1);
    chk({tag, " load iaddr"}, cif.iaddr, word_addr);
    chk({tag, " load ihit"},  32'(cif.ihit), 32'h0);
    cyc();
    $display("txn miss  addr=%h fill=%h", addr, data);
  endtask

  // One fetch that must hit with the given word.
  task automatic do_hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, addr, 1'b1, 32'h0);
    chk({tag, " ihit"},     32'(cif.ihit), 32'h1);
    chk({tag, " imemload"}, cif.imemload, data);
    chk({tag, " iREN"},     32'(cif.iREN), 32'h0);
    cyc();
    $display("txn hit   addr=%h data=%h", addr, cif.imemload);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    nRST  = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 32'h0);

    // Reset state
    cyc();
    cyc();
    chk("rst ihit",     32'(cif.ihit), 32'h0);
    chk("rst imemload", cif.imemload, 32'h0);
    chk("rst iREN",     32'(cif.iREN), 32'h0);
    chk("rst iaddr",    cif.iaddr, 32'h0);
    chk("rst hit_cnt",  dut.hit_cnt, 32'h0);
    chk("rst miss_cnt", dut.miss_cnt, 32'h0);
    nRST = 1'b1;
    cyc();

    // 1: cold miss at 0x40, 3 busy cycles -> iREN for 4 cycles, hit in cycle 6
    do_miss("t1", 32'h0000_0040, 3, 32'h2008_0001);
    do_hit("t1 cycle6", 32'h0000_0040, 32'h2008_0001);

    // 2: refetch 0x40 and 0x43 (offset ignored)
    do_hit("t2 0x40", 32'h0000_0040, 32'h2008_0001);
    do_hit("t2 0x43", 32'h0000_0043, 32'h2008_0001);
    chk("t2 hit_cnt",  dut.hit_cnt, 32'd3);
    chk("t2 miss_cnt", dut.miss_cnt, 32'd1);

    // 6: idle fetch port for 10 cycles
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0000_0040, 1'b1, 32'h0);
      chk("t6 ihit",     32'(cif.ihit), 32'h0);
      chk("t6 iREN",     32'(cif.iREN), 32'h0);
      chk("t6 imemload", cif.imemload, 32'h0);
      cyc();
    end
    chk("t6 hit_cnt",  dut.hit_cnt, 32'd3);
    chk("t6 miss_cnt", dut.miss_cnt, 32'd1);

    // 5: reset while FETCH is outstanding for 0x100
    drive(1'b1, 32'h0000_0100, 1'b1, 32'h0);
    chk("t5 miss ihit", 32'(cif.ihit), 32'h0);
    cyc();
    drive(1'b1, 32'h0000_0100, 1'b1, 32'h0);
    chk("t5 fetch iREN", 32'(cif.iREN), 32'h1);
    nRST = 1'b0;
    #1;
    chk("t5 async iREN",  32'(cif.iREN), 32'h0);
    chk("t5 async iaddr", cif.iaddr, 32'h0);
    cyc();
    nRST = 1'b1;
    drive(1'b0, 32'h0000_0100, 1'b0, 32'hBAD0_0100);
    chk("t5 post iREN",   32'(cif.iREN), 32'h0);
    chk("t5 hit_cnt",     dut.hit_cnt, 32'd0);
    chk("t5 miss_cnt",    dut.miss_cnt, 32'd0);
    cyc();

    // 3: conflict in frame 0; first 0x40 misses since reset cleared valid
    do_miss("t3 0x40a",  32'h0000_0040, 1, 32'h2008_0001);
    do_miss("t3 0x400",  32'h0000_0400, 2, 32'hDEAD_0400);
    do_miss("t3 0x40b",  32'h0000_0040, 0, 32'h2008_0001);
    chk("t3 miss_cnt",   dut.miss_cnt, 32'd3);
    do_hit("t3 frame0", 32'h0000_0040, 32'h2008_0001);

    // 4: redirect 0x80 -> 0xC0 while memory is busy
    drive(1'b1, 32'h0000_0080, 1'b1, 32'h0);
    chk("t4 miss80 ihit", 32'(cif.ihit), 32'h0);
    cyc();
    drive(1'b1, 32'h0000_00C0, 1'b1, 32'h0);
    chk("t4 redirect iaddr", cif.iaddr, 32'h0000_0080);
    chk("t4 redirect iREN",  32'(cif.iREN), 32'h1);
    cyc();
    drive(1'b1, 32'h0000_00C0, 1'b0, 32'h1111_0080);
    chk("t4 fill80 iaddr", cif.iaddr, 32'h0000_0080);
    cyc();
    drive(1'b1, 32'h0000_00C0, 1'b1, 32'h0);
    chk("t4 idle gap iREN", 32'(cif.iREN), 32'h0);
    chk("t4 missC0 ihit",   32'(cif.ihit), 32'h0);
    cyc();
    drive(1'b1, 32'h0000_00C0, 1'b0, 32'h2222_00C0);
    chk("t4 fillC0 iaddr", cif.iaddr, 32'h0000_00C0);
    chk("t4 fillC0 iREN",  32'(cif.iREN), 32'h1);
    cyc();
    $display("txn miss  addr=%h fill=%h (redirected)", 32'h0000_00C0, 32'h2222_00C0);
    do_hit("t4 hitC0", 32'h0000_00C0, 32'h2222_00C0);
    // 0x80 and 0xC0 share frame 0, so 0x80 must be refilled before it hits.
    do_miss("t4 refill80", 32'h0000_0080, 1, 32'h1111_0080);
    do_hit("t4 hit80", 32'h0000_0080, 32'h1111_0080);

    drive(1'b0, 32'h0, 1'b1, 32'h0);
    cyc();
    chk("end hit_cnt",  dut.hit_cnt, 32'd3);
    chk("end miss_cnt", dut.miss_cnt, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
